// File: rtl/sim_run_ctrl_pkg.sv
// Shared types for the simulation run controller.
//   state_e : FSM state encoding, also driven out on state_o.
//   cause_e : reason the run ended, driven out on cause_o.
package sim_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_LIMIT = 2'd1,
    CAUSE_STOP  = 2'd2,
    CAUSE_WDOG  = 2'd3
  } cause_e;

  // Counter width able to hold 0..max_val (never narrower than 1 bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sim_run_ctrl_rst_stagger.sv
// Staggered release of N_RST active-low reset channels.
// A phase counter runs while 'active' is high; channel k is released
// (registered to 1) once ph >= RST_CYCLES + k*STAGGER and stays released
// until 'clear'. all_released is the AND of the registered channels.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   clear          : restart the sequence (ph and all channels back to 0)
//   active         : FSM is in RESET, advance the phase counter
//   rst_n          : per-channel active-low reset, registered
//   all_released   : every channel is 1
module rst_stagger
  import sim_run_ctrl_pkg::*;
#(
  parameter int N_RST      = 2,
  parameter int RST_CYCLES = 11,
  parameter int STAGGER    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             active,
  output logic [N_RST-1:0] rst_n,
  output logic             all_released
);

  localparam int MAX_THR = RST_CYCLES + (N_RST - 1) * STAGGER;
  // One spare count above the last threshold so ph can saturate past it.
  localparam int PH_W    = cnt_width(MAX_THR + 1);

  logic [PH_W-1:0]  ph;
  logic [N_RST-1:0] hit;

  genvar k;
  generate
    for (k = 0; k < N_RST; k++) begin : g_ch
      localparam logic [PH_W-1:0] THR = PH_W'(RST_CYCLES + k * STAGGER);
      assign hit[k] = (ph >= THR);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ph    <= '0;
      rst_n <= '0;
    end else if (active) begin
      if (ph != '1) ph <= ph + 1'b1;
      // Sticky: once released a channel never re-asserts within RESET.
      rst_n <= rst_n | hit;
    end
  end

  assign all_released = &rst_n;

endmodule

// File: rtl/sim_run_ctrl.sv
// Reset sequencer and run-length controller for simulation tops.
// Drives staggered DUT resets, counts RUN cycles and DUT events, ends the
// run on stop request / cycle limit / optional watchdog, drains, then
// pulses finish_o once on entry to DONE.
// Optional feature: define SIM_RUN_CTRL_WDOG_EN to build the idle-event
// watchdog (cause 3). Without it no watchdog logic exists.
// Ports:
//   clk_i, reset  : clock, synchronous active-high reset
//   run_i         : start request, honoured in IDLE and DONE
//   event_i       : one-cycle DUT event strobe
//   stop_req_i    : early end request, honoured in RUN
//   rst_n_o       : per-channel active-low DUT reset
//   clk_cnt_o     : RUN cycles elapsed (saturating)
//   event_cnt_o   : events counted in RUN and DRAIN (saturating)
//   state_o       : FSM state encoding
//   cause_o       : end cause (none/limit/stop/watchdog)
//   done_o        : high while in DONE
//   finish_o      : one-cycle pulse on entry to DONE
module sim_run_ctrl
  import sim_run_ctrl_pkg::*;
#(
  parameter int N_RST        = 2,
  parameter int RST_CYCLES   = 11,
  parameter int STAGGER      = 2,
  parameter int MAX_CYCLES   = 60,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32,
  parameter int EVT_W        = 64,
  parameter int WDOG_CYCLES  = 1000
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             run_i,
  input  logic             event_i,
  input  logic             stop_req_i,
  output logic [N_RST-1:0] rst_n_o,
  output logic [CNT_W-1:0] clk_cnt_o,
  output logic [EVT_W-1:0] event_cnt_o,
  output logic [2:0]       state_o,
  output logic [1:0]       cause_o,
  output logic             done_o,
  output logic             finish_o
);

  localparam logic [CNT_W-1:0] LIM_LAST =
    (MAX_CYCLES == 0) ? '0 : CNT_W'(MAX_CYCLES - 1);
  localparam int DRN_W = cnt_width(DRAIN_CYCLES);
  localparam logic [DRN_W-1:0] DRN_LAST =
    (DRAIN_CYCLES == 0) ? '0 : DRN_W'(DRAIN_CYCLES - 1);

  state_e           state, state_n;
  cause_e           cause, end_cause;
  logic [CNT_W-1:0] clk_cnt;
  logic [EVT_W-1:0] event_cnt;
  logic [DRN_W-1:0] drain_cnt;
  logic             done, finish;
  logic             start, all_released;
  logic             stop_hit, lim_hit, wdog_hit, end_any;

  assign start = run_i && ((state == ST_IDLE) || (state == ST_DONE));

  rst_stagger #(
    .N_RST      (N_RST),
    .RST_CYCLES (RST_CYCLES),
    .STAGGER    (STAGGER)
  ) u_rst_stagger (
    .clk          (clk_i),
    .reset        (reset),
    .clear        (start),
    .active       (state == ST_RESET),
    .rst_n        (rst_n_o),
    .all_released (all_released)
  );

`ifdef SIM_RUN_CTRL_WDOG_EN
  localparam int WD_W = cnt_width(WDOG_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST =
    (WDOG_CYCLES < 1) ? '0 : WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] idle_cnt;

  // Cycles since the last event; only meaningful while in RUN.
  always_ff @(posedge clk_i) begin
    if (reset || state != ST_RUN) idle_cnt <= '0;
    else if (event_i)             idle_cnt <= '0;
    else if (idle_cnt != '1)      idle_cnt <= idle_cnt + 1'b1;
  end

  // Expires on the cycle that would make the idle count reach WDOG_CYCLES.
  assign wdog_hit = (state == ST_RUN) && !event_i && (idle_cnt == WD_LAST);
`else
  // Watchdog not built. A negative WDOG_CYCLES is meaningless, so this is
  // constant false; it keeps the parameter referenced in this build.
  assign wdog_hit = (WDOG_CYCLES < 0);
`endif

  assign stop_hit = stop_req_i;
  assign lim_hit  = (MAX_CYCLES != 0) && (clk_cnt == LIM_LAST);
  assign end_any  = stop_hit || lim_hit || wdog_hit;

  // Priority: stop > limit > watchdog.
  always_comb begin
    end_cause = CAUSE_NONE;
    if (stop_hit)      end_cause = CAUSE_STOP;
    else if (lim_hit)  end_cause = CAUSE_LIMIT;
    else if (wdog_hit) end_cause = CAUSE_WDOG;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (run_i) state_n = ST_RESET;
      ST_RESET: if (all_released) state_n = ST_RUN;
      ST_RUN:   if (end_any) state_n = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
      ST_DRAIN: if (drain_cnt == DRN_LAST) state_n = ST_DONE;
      ST_DONE:  if (run_i) state_n = ST_RESET;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state     <= ST_IDLE;
      cause     <= CAUSE_NONE;
      clk_cnt   <= '0;
      event_cnt <= '0;
      drain_cnt <= '0;
      done      <= 1'b0;
      finish    <= 1'b0;
    end else begin
      state  <= state_n;
      done   <= (state_n == ST_DONE);
      finish <= (state_n == ST_DONE) && (state != ST_DONE);

      if (state == ST_DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                   drain_cnt <= '0;

      if (start) begin
        clk_cnt   <= '0;
        event_cnt <= '0;
        cause     <= CAUSE_NONE;
      end else begin
        if (state == ST_RUN) begin
          if (clk_cnt != '1) clk_cnt <= clk_cnt + 1'b1;
          if (end_any)       cause   <= end_cause;
        end
        // Events count in RUN (including the exit cycle) and all of DRAIN.
        if ((state == ST_RUN || state == ST_DRAIN) && event_i && event_cnt != '1)
          event_cnt <= event_cnt + 1'b1;
      end
    end
  end

  assign state_o     = state;
  assign cause_o     = cause;
  assign clk_cnt_o   = clk_cnt;
  assign event_cnt_o = event_cnt;
  assign done_o      = done;
  assign finish_o    = finish;

endmodule
